// File: rtl/button_press_classifier.sv
// button_press_classifier: turns a debounced button level into one-cycle
// short / long / double press events, one instance per button.
module button_press_classifier #(
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned LONG_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_btn_q;
  logic             r_btn_d;
  logic             w_rise;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_double_nxt;

  // Input history. Both stages reset high so a button already held when reset
  // releases shows no rising edge; a gesture always needs a fresh press.
  // Falling edges are never acted on directly (IDLE ignores them; the press
  // states test the level), so only the rise detector is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_q <= 1'b1;
      r_btn_d <= 1'b1;
    end else begin
      r_btn_q <= button_in;
      r_btn_d <= r_btn_q;
    end
  end

  assign w_rise = r_btn_q & ~r_btn_d;

  // State, shared tick counter and registered event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      short_press  <= w_short_nxt;
      long_press   <= w_long_nxt;
      double_press <= w_double_nxt;
    end
  end

  // Gesture classification; every compare hit leaves its state, so the
  // counter never wraps.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESS1;
          w_cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (!r_btn_q) begin
          w_state_nxt = WAIT_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = LONG_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!r_btn_q) w_state_nxt = IDLE;
      end
      WAIT_GAP: begin
        // A second press on the timeout cycle still counts as a double.
        if (w_rise) begin
          w_state_nxt  = PRESS2;
          w_double_nxt = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_short_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (!r_btn_q) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule
